// File: rtl/instr_dispatch_queue.sv
// Instruction FIFO in front of the matrix coprocessor: screens illegal opcodes
// and issues queued words one at a time over a start/done handshake.
module instr_dispatch_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned IW         = 15,
    parameter int unsigned ILLEGAL_OP = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IW-1:0]            in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [IW-1:0]            cp_instr,
    output logic                     cp_start,
    input  logic                     cp_done,
    output logic                     busy,
    output logic                     err_illegal,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [7:0]               dispatched
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = 3;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [IW-1:0] mem [DEPTH];

    logic [OW-1:0] opcode;
    logic          push_try;
    logic          illegal;
    logic          push;
    logic          pop;
    logic          done_ack;

    // Illegal words are consumed (handshake completes) but never stored.
    assign opcode   = in_instr[IW-1 -: OW];
    assign push_try = in_valid & in_ready;
    assign illegal  = push_try & (opcode == OW'(ILLEGAL_OP));
    assign push     = push_try & ~illegal & ~flush;

    // Next-state logic; flush blocks a same-edge pop from IDLE.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        done_ack   = 1'b0;
        case (state)
            IDLE: begin
                if ((count != CW'(0)) && !flush) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cp_done) begin
                    done_ack   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Occupancy update; flush overrides any same-cycle push.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = CW'(0);
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= CW'(0);
            wr_ptr <= AW'(0);
            rd_ptr <= AW'(0);
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= AW'(0);
                rd_ptr <= AW'(0);
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Registered outputs, computed from next-state values so they line up with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cp_instr    <= IW'(0);
            cp_start    <= 1'b0;
            err_illegal <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            dispatched  <= 8'd0;
        end else begin
            if (pop) begin
                cp_instr <= mem[rd_ptr];
            end
            cp_start    <= (state_next == ISSUE);
            err_illegal <= illegal;
            in_ready    <= (count_next != CW'(DEPTH));
            busy        <= (state_next != IDLE) || (count_next != CW'(0));
            if (done_ack) begin
                dispatched <= dispatched + 8'd1;
            end
        end
    end

    assign fill_level = count;

endmodule
